// File: rtl/gate_reduce_filt.sv
// Parametrised masked-input reduction gate with a registered pipeline,
// a consecutive-sample glitch filter on the output and edge strobes.
module gate_reduce_filt #(
    parameter int          WIDTH    = 5,
    parameter logic [31:0] INV_MASK = 32'h0000_0003,
    parameter int          FUNC     = 1,
    parameter int          STAGES   = 1,
    parameter int          FILTER   = 1,
    parameter logic        INIT     = 1'b0
) (
    input  logic             C,
    input  logic             RB,
    input  logic             CE,
    input  logic [WIDTH-1:0] I,
    input  logic             IV,
    output logic             O,
    output logic             OV,
    output logic             RISE,
    output logic             FALL
);

    localparam logic [3:0] CNT_MAX = 4'(FILTER - 1);

    logic [WIDTH-1:0]  masked;
    logic              raw_r;
    logic [STAGES-1:0] pv_q, pv_d;
    logic [STAGES-1:0] pr_q, pr_d;
    logic              last_v, last_r;
    logic              o_q, o_d;
    logic              ov_q, ov_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic [3:0]        cnt_q, cnt_d;

    assign masked = I ^ INV_MASK[WIDTH-1:0];

    // Unlisted function codes fall back to AND.
    always_comb begin
        raw_r = &masked;
        case (FUNC)
            0:       raw_r = &masked;
            1:       raw_r = ~&masked;
            2:       raw_r = |masked;
            3:       raw_r = ~|masked;
            4:       raw_r = ^masked;
            5:       raw_r = ~^masked;
            default: raw_r = &masked;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign pv_d[gi] = IV;
                assign pr_d[gi] = raw_r;
            end else begin : g_next
                assign pv_d[gi] = pv_q[gi-1];
                assign pr_d[gi] = pr_q[gi-1];
            end
        end
    endgenerate

    // Bubbles (valid=0) travel through the pipe exactly like data.
    always_ff @(posedge C) begin
        if (!RB) begin
            pv_q <= '0;
            pr_q <= '0;
        end else if (CE) begin
            pv_q <= pv_d;
            pr_q <= pr_d;
        end
    end

    assign last_v = pv_q[STAGES-1];
    assign last_r = pr_q[STAGES-1];

    // Bubbles at the filter leave the count untouched.
    always_comb begin
        o_d    = o_q;
        cnt_d  = cnt_q;
        ov_d   = 1'b0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (CE && last_v) begin
            ov_d = 1'b1;
            if (last_r == o_q) begin
                cnt_d = 4'd0;
            end else if (cnt_q == CNT_MAX) begin
                o_d    = last_r;
                cnt_d  = 4'd0;
                rise_d = last_r;
                fall_d = ~last_r;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge C) begin
        if (!RB) begin
            o_q    <= INIT;
            cnt_q  <= 4'd0;
            ov_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            o_q    <= o_d;
            cnt_q  <= cnt_d;
            ov_q   <= ov_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign O    = o_q;
    assign OV   = ov_q;
    assign RISE = rise_q;
    assign FALL = fall_q;

endmodule

// File: doc/gate_reduce_filt.md
# gate_reduce_filt

Registered, parametrised successor to the fixed 5-input inverted-input NAND primitives in our unisim library. It reduces a WIDTH-bit input vector through a per-bit inversion mask and a selectable logic function, then pipelines the result. A consecutive-sample glitch filter sits after the pipeline, and the block reports output changes with single-cycle edge strobes. It sits between sampled control/status signals and downstream sequential logic that needs a clean, registered, qualified decision.

## Interface
- WIDTH, 5: number of inputs; legal range 2..32.
- INV_MASK, 5'b00011: bit i=1 inverts I[i] before reduction. The default reproduces the B2 input arrangement.
- FUNC, 1: reduction function. 0=AND, 1=NAND, 2=OR, 3=NOR, 4=XOR, 5=XNOR. Any other value is treated as AND.
- STAGES, 1: pipeline register depth after the reduction; legal range 1..4.
- FILTER, 1: number of consecutive valid disagreeing samples required to change O; legal range 1..15.
- INIT, 1'b0: value of O after reset.

Ports (one clock; reset is synchronous and active-low):
- C  in  1  clock, rising edge.
- RB  in  1  synchronous active-low reset.
- CE  in  1  clock enable. Low freezes all state.
- I  in  WIDTH  data inputs.
- IV  in  1  input valid. Samples are taken only when IV=1 and CE=1.
- O  out  1  filtered, registered result.
- OV  out  1  one-cycle strobe: a sample has reached the filter.
- RISE  out  1  one-cycle strobe: O went 0->1.
- FALL  out  1  one-cycle strobe: O went 1->0.

## Operation
- Raw result: r = FUNC applied to (I ^ INV_MASK). The reduction is combinational.
- Pipeline:
  - At each edge with CE=1, stage 1 captures {IV, r}, and stage k captures stage k-1.
  - A stage with valid=0 is a bubble. Bubbles advance like data.
- Filter:
  - Operates at each edge with CE=1 and last-stage valid=1.
  - Candidate d = last-stage r.
  - If d==O: cnt<=0.
  - Else if cnt==FILTER-1: O<=d, cnt<=0, and RISE or FALL (whichever matches the new O) is asserted for the following cycle.
  - Else: cnt<=cnt+1.
- Bubbles at the filter hold cnt; they neither clear it nor advance it.
- OV=1 in the cycle after every edge at which the filter consumed a valid sample.
- RISE, FALL and OV are 0 in every other cycle, including every cycle after an edge with CE=0.
- cnt is 4 bits wide and never exceeds FILTER-1. No wrap-around is possible.
- With FILTER=1, every valid disagreeing sample changes O immediately.

## Timing
- Reset (RB=0 at an edge) takes priority over CE. Reset state:
  - O=INIT.
  - OV=RISE=FALL=0.
  - cnt=0.
  - All pipeline valid bits and data bits are 0.
- Reset asserted mid-operation discards in-flight samples and any partial filter count.
- Outputs are defined from the first edge with RB=0.
- Latency: a sample accepted at edge k reaches the filter at edge k+STAGES. O, OV, RISE and FALL reflect that sample in the cycle after edge k+STAGES. With the defaults this is the cycle after edge k+1.
- Throughput: one sample per cycle. There is no backpressure.
- CE=0 for n cycles stretches latency by n cycles. No data is lost and no strobes are duplicated.
- If a change event and a same-cycle reset coincide, reset wins and no strobe is issued.
- All outputs are driven directly from registers.

## Test plan
- Defaults: reset, then I=5'b11100, IV=1 held -> O=0 and FALL=0 (INIT=0, so no change). Then I=5'b11101 -> O=1, with RISE=1 for exactly one cycle, 2 cycles after the sampling edge.
- FUNC=4, WIDTH=8, INV_MASK=0: I=8'hA5 -> O=0; I=8'hA4 -> O=1. Walk the applied FUNC value over 0..7 -> 6 and 7 produce the same result as AND.
- FILTER=3: apply the disagreeing value for 2 valid samples, then 1 agreeing sample, then 3 disagreeing -> O changes only after the third consecutive disagreeing sample, and the strobe count is exactly 1.
- FILTER=3 with bubbles: disagree, IV=0 for 4 cycles, disagree, disagree -> O changes. OV pulses 3 times, none of them during the bubble cycles.
- STAGES=4, with CE toggled 1,0,1,0... -> latency is 4 enabled edges, and no strobe appears in a cycle following a CE=0 edge.
- INIT=1: pulse RB low during an in-progress count (FILTER=4, cnt=2) -> O=1, cnt=0, pipeline empty. The next 3 disagreeing samples do not change O.
